sudoku_board_reader: RTL
========================

# sudoku_board_reader

Streams the contents of the 9x9 Sudoku cell store back out of the design: the reverse of the row-major cell loader. On a start pulse it walks the store's synchronous read port over a full board, one row, one column or one 3x3 box. It emits each cell with its coordinates on a valid/ready stream that feeds the output pin mux. A 2-entry buffer absorbs the 1-cycle read latency, so the block sustains 1 cell/cycle under continuous ready.

## Interface
- N, 9, board dimension (cells per row/column/box)
- CELL_W, 4, cell value width (0 = empty, 1..9 = digit)

- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  begin a dump; sampled only in IDLE
- mode  in  2  0 = full board row-major, 1 = row `sel`, 2 = column `sel`, 3 = box `sel`; sampled with start
- sel  in  4  row/column/box index 0..8; ignored for mode 0; sampled with start
- rd_en  out  1  store read strobe
- rd_row, rd_col  out  4 each  store read address
- rd_data  in  CELL_W  store data, valid exactly 1 cycle after rd_en
- out_valid  out  1  cell available
- out_ready  in  1  consumer accepts; handshake = valid & ready
- out_data  out  CELL_W  cell value
- out_row, out_col  out  4 each  cell coordinates
- out_last  out  1  final cell of this dump
- busy  out  1  dump in progress
- done  out  1  one-cycle pulse at end of dump
- err  out  1  sticky; cleared by the next accepted start

## Operation
- Reset values: every output is 0, FSM is IDLE, the buffer is empty and any in-flight read is discarded. The same applies to reset asserted mid-dump. No done pulse follows reset.
- FSM states: IDLE, RUN, DRAIN.
- IDLE: start=1 latches mode/sel, clears err and loads index=0.
  - If mode≠0 and sel>8: err=1, done pulses next cycle, no reads are issued, and the FSM stays IDLE.
  - Otherwise the FSM goes to RUN and busy=1.
- RUN: issue rd_en when (buffer occupancy + in-flight reads − pop this cycle) < 2.
  - Count = 81 for mode 0, otherwise 9.
  - After the read with index = count−1, go to DRAIN.
- DRAIN: wait until the buffer is empty and nothing is in flight.
  - The handshake on out_last moves the FSM to IDLE. busy falls and done pulses in the following cycle.
- Address generation:
  - mode 0: row = idx/9, col = idx%9.
  - mode 1: row = sel, col = idx.
  - mode 2: row = idx, col = sel.
  - mode 3: row = 3·(sel/3) + idx/3, col = 3·(sel%3) + idx%3.
  - Implement with row/col counters, not dividers.
- out_row/out_col/out_last are captured alongside rd_en and travel through the buffer with the data.
- rd_data > 9 sets err; the cell is still emitted unchanged.
- start while busy is ignored, with no effect on err or on the latched mode/sel.
- Stream stability: while out_valid=1 and out_ready=0, out_data/out_row/out_col/out_last hold steady.

## Timing
- Start is sampled at edge E0, rd_en is high in the cycle after E0, and rd_data is captured at E2. out_valid is high from E2, so the first cell is visible 2 cycles after start.
- With out_ready held at 1: one cell per cycle, no bubbles. A full dump takes 81 consecutive handshake cycles and done is 1 cycle after the last handshake. Start-to-done = 83 cycles for mode 0 and 11 cycles for modes 1–3.
- out_ready low: at most 2 cells are buffered and rd_en stalls in the same cycle. Reads resume the cycle ready returns, with no lost or duplicated cells.
- Simultaneous push and pop on a full buffer is legal; occupancy is unchanged.
- A start coincident with the done pulse is accepted, because the FSM is already in IDLE.

## Structure
- Package sudoku_pkg:
  - N and CELL_W constants.
  - mode encoding enum (MODE_BOARD, MODE_ROW, MODE_COL, MODE_BOX).
  - Cell record type {value, row, col, last}.
  - FSM state enum.
- Sub-module sudoku_cell_fifo: 2-entry synchronous FIFO of the cell record with count output, async active-high reset and a flush-on-reset requirement.
- The address generator and FSM stay in the top module.

## Test plan
- Full-board dump, store preloaded with value = (row+col)%10, out_ready=1 → 81 cells in row-major order with correct coordinates and values. out_last is set only on (8,8), done is 83 cycles after start and err=0.
- Box mode, sel=4, out_ready=1 → coordinates (3,3),(3,4),(3,5),(4,3)…(5,5), out_last on (5,5), done 11 cycles after start.
- Mode 0 with out_ready toggling 1,0,0,1 and a random pattern → exact 81-cell sequence preserved with no duplicates. Outputs hold while stalled and rd_en never leaves more than 2 cells outstanding.
- Row mode with sel=11 → err=1 and a done pulse the next cycle, with no rd_en and no out_valid. A following start with sel=2 clears err and dumps row 2.
- rst asserted after 40 handshakes of a full dump → all outputs 0 and the buffer empty immediately. A new start then dumps from (0,0).
- Store cell (6,7)=12 in column mode, sel=7 → value 12 emitted at (6,7) and err=1, still set after done.

Source files
------------

// File: rtl/sudoku_pkg.sv
// Shared constants and types for the Sudoku cell-store reader.
package sudoku_pkg;
  localparam int N      = 9;
  localparam int CELL_W = 4;

  typedef enum logic [1:0] {
    MODE_BOARD = 2'd0,
    MODE_ROW   = 2'd1,
    MODE_COL   = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  typedef struct packed {
    logic [CELL_W-1:0] value;
    logic [3:0]        row;
    logic [3:0]        col;
    logic              last;
  } cell_t;

  // Top-left row of box s, i.e. 3*(s/3), as a lookup instead of a divider.
  function automatic logic [3:0] box_row0(input logic [3:0] s);
    case (s)
      4'd0, 4'd1, 4'd2: box_row0 = 4'd0;
      4'd3, 4'd4, 4'd5: box_row0 = 4'd3;
      default:          box_row0 = 4'd6;
    endcase
  endfunction

  // Top-left column of box s, i.e. 3*(s%3).
  function automatic logic [3:0] box_col0(input logic [3:0] s);
    case (s)
      4'd0, 4'd3, 4'd6: box_col0 = 4'd0;
      4'd1, 4'd4, 4'd7: box_col0 = 4'd3;
      default:          box_col0 = 4'd6;
    endcase
  endfunction
endpackage

// File: rtl/sudoku_cell_fifo.sv
// Two-entry cell FIFO; absorbs the store's read latency and back-pressure.
module sudoku_cell_fifo
  import sudoku_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  cell_t      wdata,
  input  logic       pop,
  output cell_t      rdata,
  output logic [1:0] count
);
  cell_t [1:0] mem;
  logic        wr_ptr, rd_ptr;
  logic        do_push, do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A push onto a full FIFO is accepted when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem    <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/sudoku_board_reader.sv
// Walks the 9x9 cell store (board, row, column or box) and streams cells out.
module sudoku_board_reader
  import sudoku_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [3:0]        sel,
  output logic              rd_en,
  output logic [3:0]        rd_row,
  output logic [3:0]        rd_col,
  input  logic [CELL_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CELL_W-1:0] out_data,
  output logic [3:0]        out_row,
  output logic [3:0]        out_col,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err
);
  state_e     state, state_nxt;
  mode_e      mode_q;
  logic [3:0] col_lo;
  logic [6:0] idx, last_idx;
  logic       inflight;
  logic [3:0] pend_row, pend_col;
  logic       pend_last;
  cell_t      head, wcell;
  logic [1:0] fifo_cnt;
  logic       accept, bad_sel, pop, last_rd;

  assign accept  = (state == S_IDLE) && start;
  assign bad_sel = (mode != 2'd0) && (sel > 4'd8);
  assign pop     = out_valid && out_ready;
  assign last_rd = rd_en && (idx == last_idx);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (accept && !bad_sel) state_nxt = S_RUN;
      S_RUN:   if (last_rd) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && head.last) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Never let buffered plus in-flight cells exceed the two FIFO slots.
  always_comb begin
    busy  = (state != S_IDLE);
    rd_en = 1'b0;
    if (state == S_RUN)
      rd_en = ({1'b0, fifo_cnt} + {2'b00, inflight}) < (3'd2 + {2'b00, pop});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= MODE_BOARD;
      col_lo    <= 4'd0;
      idx       <= 7'd0;
      last_idx  <= 7'd0;
      rd_row    <= 4'd0;
      rd_col    <= 4'd0;
      inflight  <= 1'b0;
      pend_row  <= 4'd0;
      pend_col  <= 4'd0;
      pend_last <= 1'b0;
      err       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done     <= (accept && bad_sel) || ((state == S_DRAIN) && pop && head.last);
      inflight <= rd_en;
      if (rd_en) begin
        pend_row  <= rd_row;
        pend_col  <= rd_col;
        pend_last <= (idx == last_idx);
      end
      if (accept) begin
        mode_q   <= mode_e'(mode);
        idx      <= 7'd0;
        last_idx <= (mode == 2'd0) ? 7'd80 : 7'd8;
        err      <= bad_sel;
        if (!bad_sel) begin
          case (mode_e'(mode))
            MODE_BOARD: begin rd_row <= 4'd0;          rd_col <= 4'd0;          end
            MODE_ROW:   begin rd_row <= sel;           rd_col <= 4'd0;          end
            MODE_COL:   begin rd_row <= 4'd0;          rd_col <= sel;           end
            default:    begin rd_row <= box_row0(sel); rd_col <= box_col0(sel); end
          endcase
          col_lo <= box_col0(sel);
        end
      end else begin
        if (inflight && (rd_data > CELL_W'(9))) err <= 1'b1;
        if (rd_en) begin
          idx <= idx + 7'd1;
          case (mode_q)
            MODE_BOARD:
              if (rd_col == 4'd8) begin rd_col <= 4'd0; rd_row <= rd_row + 4'd1; end
              else rd_col <= rd_col + 4'd1;
            MODE_ROW: rd_col <= rd_col + 4'd1;
            MODE_COL: rd_row <= rd_row + 4'd1;
            default:
              if (rd_col == col_lo + 4'd2) begin rd_col <= col_lo; rd_row <= rd_row + 4'd1; end
              else rd_col <= rd_col + 4'd1;
          endcase
        end
      end
    end
  end

  assign wcell = '{value: rd_data, row: pend_row, col: pend_col, last: pend_last};

  sudoku_cell_fifo u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (inflight),
    .wdata (wcell),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt)
  );

  assign out_valid = (fifo_cnt != 2'd0);
  assign out_data  = head.value;
  assign out_row   = head.row;
  assign out_col   = head.col;
  assign out_last  = head.last;
endmodule
